// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the sequential multiplier.
// Holds the controller state encoding and the iteration-counter width rule.
// Imported by the controller; the adder is width-parameterised only.
package mult_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} mult_state_t;

  // Counter must be able to represent 0..m, so it needs ceil(log2(m+1)) bits.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sum_N.sv
// m-bit unsigned ripple-carry adder with carry out.
// Purely combinational; the carry chain is the multiplier's critical path.
// No flow control: inputs to outputs in the same cycle.
module sum_N #(
  parameter int m = 4
) (
  input  logic [m-1:0] a,
  input  logic [m-1:0] b,
  output logic [m-1:0] y,
  output logic         cout
);

  logic [m:0] c;

  // Bit-serial carry propagation from LSB to MSB.
  always_comb begin
    c    = '0;
    y    = '0;
    for (int i = 0; i < m; i++) begin
      y[i]     = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[m];
  end

endmodule

// File: rtl/mult_seq_n.sv
// Shift-and-add unsigned multiplier sharing one m-bit adder over m iterations.
// Latency: done pulses in the cycle after edge m (accepting edge = edge 0).
// start is only sampled in IDLE; requests during CALC/DONE are dropped.
module mult_seq_n
  import mult_pkg::*;
#(
  parameter int m = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [m-1:0]   a,
  input  logic [m-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*m-1:0] p
);

  localparam int CW = cnt_width(m);

  mult_state_t       state, state_nxt;
  logic [m-1:0]      mcand;   // multiplicand
  logic [m-1:0]      acc;     // product high half
  logic [m-1:0]      mq;      // multiplier, shifted out as product low half fills in
  logic [CW-1:0]     cnt;
  logic [2*m-1:0]    p_r;

  logic [m-1:0]      add_b;
  logic [m-1:0]      sum_y;
  logic              sum_cout;
  logic [2*m-1:0]    shifted;
  logic              last_iter;

  sum_N #(.m(m)) u_sum (
    .a    (acc),
    .b    (add_b),
    .y    (sum_y),
    .cout (sum_cout)
  );

  // Carry is kept: {cout, y, Q} shifted right by one drops only Q[0].
  assign shifted   = {sum_cout, sum_y, mq[m-1:1]};
  assign last_iter = (cnt == CW'(m - 1));

  // Next-state decode and adder operand gating on the multiplier LSB.
  always_comb begin
    state_nxt = state;
    add_b     = mq[0] ? mcand : '0;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (last_iter) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation and clears p.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mcand <= '0;
      acc   <= '0;
      mq    <= '0;
      cnt   <= '0;
      p_r   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            mcand <= a;
            acc   <= '0;
            mq    <= b;
            cnt   <= '0;
          end
        end
        CALC: begin
          {acc, mq} <= shifted;
          cnt       <= cnt + CW'(1);
          if (last_iter) p_r <= shifted;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == CALC);
  assign done = (state == DONE);
  assign p    = p_r;

endmodule

// File: tb/tb_mult_seq_n.sv
// Self-checking bench for mult_seq_n at m=4 and m=8.
// Expected products are queued on each accepted start and popped on done.
// Handshake timing is checked cycle by cycle around every operation.
module tb_mult_seq_n;

  logic        clk = 1'b0;
  logic        rst;

  logic        start4;
  logic [3:0]  a4, b4;
  logic        busy4, done4;
  logic [7:0]  p4;

  logic        start8;
  logic [7:0]  a8, b8;
  logic        busy8, done8;
  logic [15:0] p8;

  int n_chk  = 0;
  int n_pass = 0;
  int q4[$];
  int q8[$];

  always #5 clk = ~clk;

  mult_seq_n #(.m(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .p(p4)
  );

  mult_seq_n #(.m(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .p(p8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Scoreboards: every done must match a queued product.
  always @(negedge clk) begin
    if (done4) begin
      check("done4_has_expected", 32'(q4.size() != 0), 1);
      if (q4.size() != 0) check("p4_on_done", 32'(p4), 32'(q4.pop_front()));
    end
    if (done8) begin
      check("done8_has_expected", 32'(q8.size() != 0), 1);
      if (q8.size() != 0) check("p8_on_done", 32'(p8), 32'(q8.pop_front()));
    end
  end

  // One operation with a single-cycle start, checking busy/done timing.
  task automatic run_op(input bit wide, input int av, input int bv);
    int mm;
    int prod;
    mm   = wide ? 8 : 4;
    prod = av * bv;
    @(negedge clk);
    if (wide) begin
      a8 = av[7:0]; b8 = bv[7:0]; start8 = 1'b1; q8.push_back(prod);
    end else begin
      a4 = av[3:0]; b4 = bv[3:0]; start4 = 1'b1; q4.push_back(prod);
    end
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0;
    start8 = 1'b0;
    a4 = 4'hA; b4 = 4'h5; a8 = 8'hA5; b8 = 8'h5A;  // late operand changes must not matter
    for (int k = 0; k < mm; k++) begin
      check("busy_calc", 32'(wide ? busy8 : busy4), 1);
      check("done_early", 32'(wide ? done8 : done4), 0);
      @(negedge clk);
    end
    check("busy_in_done", 32'(wide ? busy8 : busy4), 0);
    check("done_pulse", 32'(wide ? done8 : done4), 1);
    @(negedge clk);
    check("done_one_cycle", 32'(wide ? done8 : done4), 0);
    check("p_hold", wide ? 32'(p8) : 32'(p4), 32'(prod));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    start4 = 1'b0; a4 = '0; b4 = '0;
    start8 = 1'b0; a8 = '0; b8 = '0;
    repeat (3) @(negedge clk);
    check("rst_busy4", 32'(busy4), 0);
    check("rst_done4", 32'(done4), 0);
    check("rst_p4", 32'(p4), 0);
    check("rst_busy8", 32'(busy8), 0);
    check("rst_p8", 32'(p8), 0);
    rst = 1'b0;

    // Directed cases.
    run_op(1'b0, 3, 5);
    run_op(1'b0, 15, 15);
    run_op(1'b0, 0, 9);
    run_op(1'b0, 9, 0);

    // start during CALC is dropped: only 7*6 completes.
    @(negedge clk);
    a4 = 4'd7; b4 = 4'd6; start4 = 1'b1; q4.push_back(42);
    @(posedge clk);
    @(negedge clk); start4 = 1'b0;
    @(negedge clk); a4 = 4'd2; b4 = 4'd2; start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    repeat (8) @(negedge clk);
    check("ignored_start_drained", 32'(q4.size()), 0);

    // start held high: re-accepted every m+2 = 6 edges.
    a4 = 4'd5; b4 = 4'd3; start4 = 1'b1;
    repeat (3) q4.push_back(15);
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      check("held_done_spacing", 32'(done4), 32'((i % 6) == 4));
      if (i == 12) start4 = 1'b0;
    end
    check("held_drained", 32'(q4.size()), 0);

    // Reset on the second CALC cycle aborts 13*11.
    @(negedge clk);
    a4 = 4'd13; b4 = 4'd11; start4 = 1'b1;
    @(posedge clk);
    @(negedge clk); start4 = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("abort_busy", 32'(busy4), 0);
    check("abort_done", 32'(done4), 0);
    check("abort_p", 32'(p4), 0);
    repeat (8) @(negedge clk);
    run_op(1'b0, 13, 11);

    // start and rst together: nothing accepted.
    @(negedge clk);
    rst = 1'b1; start4 = 1'b1; a4 = 4'd3; b4 = 4'd3;
    @(negedge clk);
    rst = 1'b0; start4 = 1'b0;
    check("rst_start_busy", 32'(busy4), 0);

    // Wide instance.
    run_op(1'b1, 255, 255);
    run_op(1'b1, 200, 3);

    // Exhaustive m=4 sweep.
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        run_op(1'b0, x, y);

    // A few random wide operations.
    repeat (10) run_op(1'b1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));

    repeat (4) @(negedge clk);
    check("q4_empty", 32'(q4.size()), 0);
    check("q8_empty", 32'(q8.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mult_seq_n.md
# mult_seq_N

Sequential shift-and-add unsigned multiplier controller that time-shares one `sum_N` ripple adder over `m` iterations to form a `2m`-bit product. It sits between a requester, which uses a start/done handshake, and the existing adder datapath. It sequences the operand registers, the adder and the product shift on every clock edge.

## Interface

Parameters
- `m`, default 4: operand width in bits; adder width; iteration count (m ≥ 2).

Ports (one clock; reset is synchronous and active-high)
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  synchronous active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `a`  in  m  multiplicand, unsigned; captured on the accepting edge.
- `b`  in  m  multiplier, unsigned; captured on the accepting edge.
- `busy`  out  1  high while in CALC.
- `done`  out  1  one-cycle pulse; product valid.
- `p`  out  2m  product; holds its value until the next accepted start.

## Operation

- Registers:
  - `M` (m bits): multiplicand.
  - `A` (m bits): accumulator high half.
  - `Q` (m bits): multiplier, which becomes the product low half.
  - `cnt` (ceil(log2(m+1)) bits).
  - `p_r` (2m bits): drives `p`.
- FSM states and transitions:
  - IDLE: if `start`, load `M←a`, `A←0`, `Q←b`, `cnt←0`, then go to CALC. Otherwise stay.
  - CALC, one iteration per edge:
    - Adder inputs are `A` and (`Q[0]` ? `M` : 0); output is `{cout,y}`.
    - `{A,Q} ← {cout, y, Q[m-1:1]}`, a 2m+1-bit value shifted right by 1. `cout` is never dropped.
    - `cnt←cnt+1`.
    - On the edge where `cnt==m-1`, also load `p_r←` the shifted `{A,Q}` and go to DONE.
  - DONE: `done=1` for exactly this cycle, then go to IDLE unconditionally.
- Width rule: the result is exact. The maximum is `(2^m-1)^2 < 2^(2m)`, so there is no overflow.
- `start` in CALC or DONE is ignored and not queued. Operand changes after the accepting edge have no effect.
- `busy` and `done` are decoded from state. `p` is registered.

## Timing

- Reset values: state=IDLE, `busy=0`, `done=0`, `p=0`, all internal registers 0.
- Define the accepting edge (IDLE with `start=1`) as edge 0.
  - `busy=1` in the cycles after edges 0 through m-1.
  - `p` updates and state enters DONE on edge m.
  - `done=1` in the cycle after edge m.
  - IDLE is reached at edge m+1.
- Latency is m+1 cycles from the accepting edge to `done`. Minimum issue interval is m+2 cycles: a `start` held high is re-accepted at edge m+2.
- Synchronous `rst` wins over every other event on the same edge, including in CALC. An aborted operation produces no `done`, and `p` returns to 0.
- `start` and `rst` high on the same edge: reset wins and nothing is accepted.
- Adder path: register → `sum_N` → register in one cycle. This is the critical path (ripple of m bits).

## Structure

- Shared package `mult_pkg`:
  - `typedef enum logic [1:0] {IDLE, CALC, DONE} mult_state_t`.
  - Localparam helper for the `cnt` width.
- One sub-module: the existing `sum_N #(.m(m))` instance.
  - Inputs: `A` and the gated `M`.
  - Outputs: `cout`, `y`.
  - The controller contains no other arithmetic except the `cnt` increment.
- One `always_ff` block holds state and registers. One `always_comb` block holds next-state logic and the adder operand mux.

## Test plan

- Basic product, m=4, `a=3`, `b=5`, one-cycle `start`: `busy` high for 4 cycles, `done` high exactly 5 cycles after the accepting edge, `p=8'h0F`, `p` held after `done`.
- Carry path, m=4, `a=15`, `b=15`: `p=8'hE1` (225). Checks that `cout` is shifted in and not lost.
- Zero operand, m=4, `a=0`, `b=9`, then `a=9`, `b=0`: both give `p=0`, with `done` timing unchanged.
- Ignored start: pulse `start` with new operands (`a=2`, `b=2`) during CALC of 7×6. Result is `p=42` and no extra `done`. With `start` held high continuously, operations issue every 6 cycles (m=4).
- Reset mid-operation: assert `rst` on the second CALC cycle of 13×11. Next cycle: `busy=0`, `done=0`, `p=0`, and no `done` follows. A fresh 13×11 then yields `p=143`.
- Width sweep, m=8: `a=255`, `b=255` gives `p=16'hFE01` with latency 9. Exhaustive random checks for m=4 against a reference product.
